// File: rtl/riscv_lsu_if.sv
// Core-side request/response and data-memory bus signals of the load-store unit.
// The master modport is the LSU; the slave modport is the core plus data RAM.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o, core_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o, core_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit: one word-aligned bus transaction per core request, IDLE->ACCESS->DONE.
// Stalls the core until mem_ready_i (or watchdog expiry); errors skip the bus and stall one cycle.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  riscv_lsu_if.master  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state, state_nxt;
  logic           we_q;
  logic [2:0]     size_q;
  logic [1:0]     off_q;
  logic [3:0]     be_q;
  logic [31:0]    addr_q;
  logic [31:0]    wd_q;
  logic [31:0]    rd_q;
  logic           err_q;
  logic [CW-1:0]  wd_cnt;

  logic           req_err;
  logic [3:0]     be_nxt;
  logic [31:0]    wd_nxt;
  logic [31:0]    rd_shift;
  logic [31:0]    load_val;
  logic           wd_hit;

  always_comb begin
    req_err = 1'b0;
    if (bus.core_we_i)
      req_err = (bus.core_size_i >= 3'd3);
    else
      req_err = (bus.core_size_i == 3'd3) || (bus.core_size_i == 3'd6) ||
                (bus.core_size_i == 3'd7);
    // size[1:0]==1 covers both H and HU
    if (bus.core_size_i[1:0] == 2'd1 && bus.core_addr_i[0])
      req_err = 1'b1;
    if (bus.core_size_i == 3'd2 && bus.core_addr_i[1:0] != 2'd0)
      req_err = 1'b1;
  end

  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = 32'd0;
    if (bus.core_we_i) begin
      case (bus.core_size_i[1:0])
        2'd0: begin
          be_nxt = 4'b0001 << bus.core_addr_i[1:0];
          wd_nxt = {4{bus.core_wd_i[7:0]}};
        end
        2'd1: begin
          be_nxt = 4'b0011 << bus.core_addr_i[1:0];
          wd_nxt = {2{bus.core_wd_i[15:0]}};
        end
        default: begin
          be_nxt = 4'b1111;
          wd_nxt = bus.core_wd_i;
        end
      endcase
    end
  end

  always_comb begin
    rd_shift = bus.mem_rd_i >> {off_q, 3'b000};
    case (size_q)
      3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd2:    load_val = rd_shift;
      3'd4:    load_val = {24'd0, rd_shift[7:0]};
      3'd5:    load_val = {16'd0, rd_shift[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // Counter holds ACCESS cycles already spent; the hit fires on the last allowed one.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.core_req_i) state_nxt = req_err ? DONE : ACCESS;
      ACCESS:  if (bus.mem_ready_i || wd_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      size_q <= 3'd0;
      off_q  <= 2'd0;
      be_q   <= 4'd0;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
      rd_q   <= 32'd0;
      err_q  <= 1'b0;
      wd_cnt <= '0;
    end else if (state == IDLE && bus.core_req_i) begin
      we_q   <= bus.core_we_i;
      size_q <= bus.core_size_i;
      off_q  <= bus.core_addr_i[1:0];
      be_q   <= be_nxt;
      addr_q <= {bus.core_addr_i[31:2], 2'b00};
      wd_q   <= wd_nxt;
      rd_q   <= 32'd0;
      err_q  <= req_err;
      wd_cnt <= '0;
    end else if (state == ACCESS) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (bus.mem_ready_i) begin
        rd_q  <= we_q ? 32'd0 : load_val;
        err_q <= 1'b0;
      end else if (wd_hit) begin
        rd_q  <= 32'd0;
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_req_o    = (state == ACCESS);
    bus.mem_we_o     = (state == ACCESS) && we_q;
    bus.mem_be_o     = (state == ACCESS) ? be_q : 4'd0;
    bus.mem_addr_o   = (state == ACCESS) ? addr_q : 32'd0;
    bus.mem_wd_o     = (state == ACCESS) ? wd_q : 32'd0;
    bus.core_rd_o    = (state == DONE) ? rd_q : 32'd0;
    bus.core_err_o   = (state == DONE) && err_q;
    bus.core_stall_o = bus.core_req_i && (state != DONE) && !rst_i;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads/stores, lane and extension cases, errors, wait states,
// watchdog timeout and asynchronous reset mid-transaction.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_lsu_if bus();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  int          r_stall, r_acc;
  logic        r_done, r_err, r_we, r_stable, r_mreq_done, r_idle_err;
  logic [31:0] r_rd, r_addr, r_wd, r_idle_rd;
  logic [3:0]  r_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and act as memory; ready rises on ACCESS cycle rdy_lat+1.
  task automatic run_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdy_lat, input logic [31:0] rdata);
    r_stall = 0; r_acc = 0; r_done = 0; r_err = 0; r_rd = 0; r_stable = 1;
    r_addr = 0; r_be = 0; r_wd = 0; r_we = 0; r_mreq_done = 0;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_rd_i    = rdata;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.core_stall_o) begin
        r_done = 1; r_rd = bus.core_rd_o; r_err = bus.core_err_o;
        r_mreq_done = bus.mem_req_o;
        break;
      end
      r_stall++;
      if (bus.mem_req_o) begin
        if (r_acc == 0) begin
          r_addr = bus.mem_addr_o; r_be = bus.mem_be_o;
          r_wd = bus.mem_wd_o; r_we = bus.mem_we_o;
        end else if (bus.mem_addr_o !== r_addr || bus.mem_be_o !== r_be ||
                     bus.mem_wd_o !== r_wd || bus.mem_we_o !== r_we) begin
          r_stable = 0;
        end
        r_acc++;
        bus.mem_ready_i = (r_acc > rdy_lat);
      end else begin
        bus.mem_ready_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    check("done_reached", 32'(r_done), 32'd1);
    @(posedge clk); #1;
    r_idle_err = bus.core_err_o;
    r_idle_rd  = bus.core_rd_o;
  endtask

  initial begin
    rst = 1'b1;
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_size_i = 0;
    bus.core_addr_i = 0; bus.core_wd_i = 0; bus.mem_rd_i = 0; bus.mem_ready_i = 0;
    #12;
    check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_stall",   32'(bus.core_stall_o), 32'd0);
    check("rst_err",     32'(bus.core_err_o), 32'd0);
    check("rst_rd",      bus.core_rd_o, 32'd0);
    check("rst_be",      32'(bus.mem_be_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW, single-cycle memory
    run_req(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_addr",  r_addr, 32'h100);
    check("lw_be",    32'(r_be), 32'hF);
    check("lw_we",    32'(r_we), 32'd0);
    check("lw_stall", 32'(r_stall), 32'd2);
    check("lw_rd",    r_rd, 32'hDEADBEEF);
    check("lw_err",   32'(r_err), 32'd0);
    check("lw_done_mreq", 32'(r_mreq_done), 32'd0);
    check("lw_idle_rd",   r_idle_rd, 32'd0);

    // Byte/halfword extraction and extension
    run_req(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80AA5511);
    check("lb_103", r_rd, 32'hFFFFFF80);
    check("lb_103_addr", r_addr, 32'h100);
    run_req(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80AA5511);
    check("lbu_103", r_rd, 32'h00000080);
    run_req(1'b0, 3'd1, 32'h102, 32'h0, 0, 32'h80AA5511);
    check("lh_102", r_rd, 32'hFFFF80AA);
    run_req(1'b0, 3'd5, 32'h102, 32'h0, 0, 32'h80AA5511);
    check("lhu_102", r_rd, 32'h000080AA);
    run_req(1'b0, 3'd0, 32'h101, 32'h0, 0, 32'h80AA5511);
    check("lb_101", r_rd, 32'h00000055);

    // Stores: lane enables and replication
    run_req(1'b1, 3'd1, 32'h206, 32'h1234ABCD, 0, 32'h0);
    check("sh_addr", r_addr, 32'h204);
    check("sh_be",   32'(r_be), 32'hC);
    check("sh_wd",   r_wd, 32'hABCDABCD);
    check("sh_we",   32'(r_we), 32'd1);
    check("sh_rd",   r_rd, 32'd0);
    run_req(1'b1, 3'd0, 32'h201, 32'h1234ABCD, 0, 32'h0);
    check("sb_be", 32'(r_be), 32'h2);
    check("sb_wd", r_wd, 32'hCDCDCDCD);
    run_req(1'b1, 3'd2, 32'h208, 32'h11223344, 0, 32'h0);
    check("sw_be", 32'(r_be), 32'hF);
    check("sw_wd", r_wd, 32'h11223344);

    // Error requests never touch the bus
    run_req(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
    check("err_lw_mis_acc",   32'(r_acc), 32'd0);
    check("err_lw_mis_err",   32'(r_err), 32'd1);
    check("err_lw_mis_stall", 32'(r_stall), 32'd1);
    check("err_lw_idle_err",  32'(r_idle_err), 32'd0);
    run_req(1'b1, 3'd1, 32'h3, 32'h0, 0, 32'h0);
    check("err_sh_mis_acc", 32'(r_acc), 32'd0);
    check("err_sh_mis_err", 32'(r_err), 32'd1);
    run_req(1'b0, 3'd6, 32'h0, 32'h0, 0, 32'h0);
    check("err_size6_err",   32'(r_err), 32'd1);
    check("err_size6_stall", 32'(r_stall), 32'd1);
    run_req(1'b1, 3'd4, 32'h0, 32'h0, 0, 32'h0);
    check("err_sbu_err", 32'(r_err), 32'd1);
    check("err_sbu_acc", 32'(r_acc), 32'd0);

    // Wait states: ready low three cycles
    run_req(1'b0, 3'd2, 32'h300, 32'h0, 3, 32'h01234567);
    check("ws_acc",    32'(r_acc), 32'd4);
    check("ws_stable", 32'(r_stable), 32'd1);
    check("ws_stall",  32'(r_stall), 32'd5);
    check("ws_rd",     r_rd, 32'h01234567);
    check("ws_err",    32'(r_err), 32'd0);

    // Watchdog: ready never arrives
    run_req(1'b0, 3'd2, 32'h400, 32'h0, 100, 32'h55555555);
    check("to_acc",     32'(r_acc), 32'd4);
    check("to_err",     32'(r_err), 32'd1);
    check("to_rd",      r_rd, 32'd0);
    check("to_idle_err", 32'(r_idle_err), 32'd0);

    // Asynchronous reset in the middle of ACCESS
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h40; bus.mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_pre_req", 32'(bus.mem_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req",   32'(bus.mem_req_o), 32'd0);
    check("rst_mid_stall", 32'(bus.core_stall_o), 32'd0);
    check("rst_mid_addr",  bus.mem_addr_o, 32'd0);
    bus.core_req_i = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_post_err", 32'(bus.core_err_o), 32'd0);
    check("rst_post_req", 32'(bus.mem_req_o), 32'd0);
    run_req(1'b0, 3'd2, 32'h40, 32'h0, 0, 32'hCAFEF00D);
    check("rst_lw_rd",    r_rd, 32'hCAFEF00D);
    check("rst_lw_stall", 32'(r_stall), 32'd2);
    check("rst_lw_addr",  r_addr, 32'h40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
